// File: rtl/heap_array_allocator.sv
// heap_array_allocator
//   Array allocator that sits in front of the executor's heap.
//   An allocate request reuses the most recently freed array, taken from a
//   LIFO free stack. If no freed array is available, it takes the next
//   fresh index from a bump counter. Before the index is returned, the
//   array's heap words and its size entry are zeroed. A free request
//   returns the array to the free stack and leaves the heap words alone.
//
// Ports
//   clock, reset     single clock; asynchronous active-high reset
//   req_valid/ready  request handshake; req_ready is high only in IDLE
//   req_free         0 = allocate, 1 = free
//   req_array        index to free (ignored on allocate)
//   resp_valid/ready response handshake
//   resp_array       allocated or freed index (0 on error)
//   resp_error       no capacity on allocate, or a bad or unused index on free
//   clr_we/clr_addr  heap clear port (write data is implicitly 0)
//   size_clr_we      one-cycle strobe: arraySizes[size_clr_array] <- 0
//   size_clr_array   array whose size entry is being zeroed
//   allocs           high-water count of fresh allocations (saturates at NArrays)
//   in_use           number of arrays currently allocated
//
// Handshake rule, used on both sides: a transfer happens on a rising clock
// edge where valid && ready. Once valid is raised, it and its payload stay
// stable until that edge.
module heap_array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 4,
  parameter int NArea              = 6,
  localparam int HeapAddrWidth     = $clog2(NArrays * NArea)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_free,
  input  logic [MemoryElementWidth-1:0] req_array,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [MemoryElementWidth-1:0] resp_array,
  output logic                          resp_error,
  output logic                          clr_we,
  output logic [HeapAddrWidth-1:0]      clr_addr,
  output logic                          size_clr_we,
  output logic [MemoryElementWidth-1:0] size_clr_array,
  output logic [MemoryElementWidth-1:0] allocs,
  output logic [MemoryElementWidth-1:0] in_use
);

  localparam int IW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int KW = (NArea > 1) ? $clog2(NArea) : 1;
  localparam logic [MemoryElementWidth-1:0] NARR_W  = MemoryElementWidth'(NArrays);
  localparam logic [HeapAddrWidth-1:0]      NAREA_H = HeapAddrWidth'(NArea);
  localparam logic [KW-1:0]                 K_LAST  = KW'(NArea - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RESP} state_t;

  state_t state, state_nxt;

  // Free stack: sp counts the entries; the top entry is stack[sp-1].
  logic [IW-1:0]      stack [NArrays];
  logic [IW:0]        sp, sp_m1;
  logic [NArrays-1:0] bitmap;
  logic [KW-1:0]      k;

  logic          accept, stack_nonempty, can_bump, alloc_ok, free_ok, clr_last;
  logic [IW-1:0] top_idx, alloc_idx, free_idx;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign clr_we     = (state == CLEAR);

  assign accept         = req_valid && req_ready;
  assign sp_m1          = sp - 1'b1;
  assign stack_nonempty = (sp != '0);
  assign top_idx        = stack[sp_m1[IW-1:0]];
  assign can_bump       = (allocs < NARR_W);
  assign alloc_ok       = stack_nonempty || can_bump;
  // allocs is below NArrays whenever it is used as the index, so its low bits are the full index.
  assign alloc_idx      = stack_nonempty ? top_idx : allocs[IW-1:0];
  assign free_idx       = req_array[IW-1:0];
  // The range test is done at full width first, so the bitmap is only consulted for legal indices.
  assign free_ok        = (req_array < NARR_W) && bitmap[free_idx];
  assign clr_last       = (k == K_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (!req_free && alloc_ok) ? CLEAR : RESP;
      CLEAR:   if (clr_last) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      k              <= '0;
      clr_addr       <= '0;
      size_clr_we    <= 1'b0;
      size_clr_array <= '0;
      resp_array     <= '0;
      resp_error     <= 1'b0;
      allocs         <= '0;
      in_use         <= '0;
      bitmap         <= '0;
      sp             <= '0;
    end else begin
      state       <= state_nxt;
      size_clr_we <= 1'b0;

      // Step through the NArea words of the array being cleared.
      if (state == CLEAR) begin
        if (clr_last) begin
          k <= '0;
        end else begin
          k        <= k + 1'b1;
          clr_addr <= clr_addr + 1'b1;
        end
      end

      if (accept) begin
        if (!req_free) begin
          if (alloc_ok) begin
            bitmap[alloc_idx] <= 1'b1;
            in_use            <= in_use + 1'b1;
            k                 <= '0;
            clr_addr          <= HeapAddrWidth'(alloc_idx) * NAREA_H;
            size_clr_we       <= 1'b1;
            size_clr_array    <= MemoryElementWidth'(alloc_idx);
            resp_array        <= MemoryElementWidth'(alloc_idx);
            resp_error        <= 1'b0;
            if (stack_nonempty) sp <= sp_m1;
            else                allocs <= allocs + 1'b1;
          end else begin
            resp_array <= '0;
            resp_error <= 1'b1;
          end
        end else if (free_ok) begin
          bitmap[free_idx] <= 1'b0;
          sp               <= sp + 1'b1;
          in_use           <= in_use - 1'b1;
          resp_array       <= req_array;
          resp_error       <= 1'b0;
        end else begin
          resp_array <= '0;
          resp_error <= 1'b1;
        end
      end
    end
  end

  // Stack storage needs no reset. Only entries below sp are ever read.
  // A rejected double free cannot push, so sp never exceeds NArrays.
  always_ff @(posedge clock) begin
    if (accept && req_free && free_ok) stack[sp[IW-1:0]] <= free_idx;
  end

endmodule

// File: tb/tb_heap_array_allocator.sv
// Directed testbench for heap_array_allocator.
// It runs a set of allocate and free sequences with hand-computed
// expectations. A scoreboard queue holds the expected heap clear addresses.
module tb_heap_array_allocator;

  logic        clock, reset;
  logic        req_valid, req_ready, req_free;
  logic [11:0] req_array;
  logic        resp_valid, resp_ready;
  logic [11:0] resp_array;
  logic        resp_error;
  logic        clr_we;
  logic [4:0]  clr_addr;
  logic        size_clr_we;
  logic [11:0] size_clr_array;
  logic [11:0] allocs, in_use;

  int n_tests = 0;
  int n_fail  = 0;
  logic       sb_en = 1'b1;
  logic [4:0] exp_q[$];

  heap_array_allocator dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_free(req_free), .req_array(req_array),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_array(resp_array), .resp_error(resp_error),
    .clr_we(clr_we), .clr_addr(clr_addr),
    .size_clr_we(size_clr_we), .size_clr_array(size_clr_array),
    .allocs(allocs), .in_use(in_use)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every heap clear write must match the next expected address
  always @(negedge clock) begin
    if (sb_en && !reset && clr_we) begin
      if (exp_q.size() == 0) check("clr_unexpected", 32'(exp_q.size()), 1);
      else                   check("clr_addr", clr_addr, exp_q.pop_front());
    end
  end

  // driver: one request, one response, optionally holding resp_ready low
  task automatic request(input string tag, input logic fr, input logic [11:0] arr,
                         input logic [11:0] exp_arr, input logic exp_err, input int hold);
    int w, lat, nclr, nsz;
    logic [11:0] sz_arr;
    logic alloc_ok;
    alloc_ok = !fr && !exp_err;
    if (alloc_ok)
      for (int k = 0; k < 6; k++) exp_q.push_back(5'(exp_arr * 6 + k));
    @(negedge clock);
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clock); w++; end
    check({tag, "_ready_wait"}, 32'(w < 50), 1);
    req_valid = 1'b1; req_free = fr; req_array = arr;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; req_free = ~fr; req_array = 12'($urandom_range(0, 4095));
    lat = 1; nclr = 0; nsz = 0; sz_arr = '0;
    while (!resp_valid && lat < 50) begin
      if (clr_we) nclr++;
      if (size_clr_we) begin nsz++; sz_arr = size_clr_array; end
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, lat, alloc_ok ? 7 : 1);
    check({tag, "_clr_cycles"}, nclr, alloc_ok ? 6 : 0);
    check({tag, "_size_clr_pulses"}, nsz, alloc_ok ? 1 : 0);
    if (alloc_ok) check({tag, "_size_clr_array"}, sz_arr, exp_arr);
    check({tag, "_resp_array"}, resp_array, exp_arr);
    check({tag, "_resp_error"}, resp_error, exp_err);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_free = 1'b1; req_array = 12'($urandom_range(0, 4095));
      check({tag, "_hold_valid"}, resp_valid, 1);
      check({tag, "_hold_array"}, resp_array, exp_arr);
      check({tag, "_hold_error"}, resp_error, exp_err);
      check({tag, "_hold_req_ready"}, req_ready, 0);
      @(negedge clock);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check({tag, "_resp_drop"}, resp_valid, 0);
    check({tag, "_ready_back"}, req_ready, 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_free = 1'b0; req_array = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_clr_we", clr_we, 0);
    check("rst_allocs", allocs, 0);
    check("rst_in_use", in_use, 0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_req_ready", req_ready, 1);

    // 1: four fresh allocations, in order, each clearing its own heap area
    request("t1_a0", 1'b0, 12'd0, 12'd0, 1'b0, 0);
    request("t1_a1", 1'b0, 12'd0, 12'd1, 1'b0, 0);
    request("t1_a2", 1'b0, 12'd0, 12'd2, 1'b0, 0);
    request("t1_a3", 1'b0, 12'd0, 12'd3, 1'b0, 0);
    check("t1_allocs", allocs, 4);
    check("t1_in_use", in_use, 4);

    // 2: out of capacity
    request("t2_full", 1'b0, 12'd0, 12'd0, 1'b1, 0);
    check("t2_allocs", allocs, 4);
    check("t2_in_use", in_use, 4);

    // 3: LIFO reuse
    request("t3_free2", 1'b1, 12'd2, 12'd2, 1'b0, 0);
    request("t3_free1", 1'b1, 12'd1, 12'd1, 1'b0, 0);
    check("t3_in_use_mid", in_use, 2);
    request("t3_re1", 1'b0, 12'd0, 12'd1, 1'b0, 0);
    request("t3_re2", 1'b0, 12'd0, 12'd2, 1'b0, 0);
    check("t3_allocs", allocs, 4);
    check("t3_in_use", in_use, 4);

    // 4: double free and out-of-range free
    request("t4_free3", 1'b1, 12'd3, 12'd3, 1'b0, 0);
    request("t4_free3_again", 1'b1, 12'd3, 12'd0, 1'b1, 0);
    request("t4_free7", 1'b1, 12'd7, 12'd0, 1'b1, 0);
    check("t4_in_use", in_use, 3);

    // 5: response back-pressure for 5 cycles
    request("t5_hold", 1'b0, 12'd0, 12'd3, 1'b0, 5);
    check("t5_in_use", in_use, 4);

    // 6: reset during the third clear cycle of an allocation
    request("t6_free2", 1'b1, 12'd2, 12'd2, 1'b0, 0);
    check("t6_sb_empty", 32'(exp_q.size()), 0);
    sb_en = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_free = 1'b0; req_array = '0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("t6_clr1_we", clr_we, 1);
    check("t6_clr1_addr", clr_addr, 12);
    check("t6_size_clr_we", size_clr_we, 1);
    @(negedge clock);
    @(negedge clock);
    check("t6_clr3_addr", clr_addr, 14);
    reset = 1'b1;
    #1;
    check("t6_rst_clr_we", clr_we, 0);
    check("t6_rst_clr_addr", clr_addr, 0);
    check("t6_rst_size_clr_we", size_clr_we, 0);
    check("t6_rst_size_clr_array", size_clr_array, 0);
    check("t6_rst_resp_valid", resp_valid, 0);
    check("t6_rst_resp_array", resp_array, 0);
    check("t6_rst_resp_error", resp_error, 0);
    check("t6_rst_allocs", allocs, 0);
    check("t6_rst_in_use", in_use, 0);
    @(negedge clock);
    reset = 1'b0;
    sb_en = 1'b1;
    @(negedge clock);
    check("t6_req_ready", req_ready, 1);
    request("t6_after", 1'b0, 12'd0, 12'd0, 1'b0, 0);
    check("t6_allocs", allocs, 1);
    check("t6_in_use", in_use, 1);

    repeat (2) @(negedge clock);
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
